// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for a five-stage MIPS pipeline.
// Shadows the ID/EX, EX/MEM and MEM/WB register-usage fields so that EX forwarding selects and PC/IF/ID stall controls can be produced locally.
module fwd_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fa,
    output logic [1:0]       fb,
    output logic             stall,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_IDEX  = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    logic [4:0] ex_rs, ex_rt, ex_dest;
    logic       ex_regwrite, ex_memread;
    logic [4:0] mem_dest, wb_dest;
    logic       mem_regwrite, wb_regwrite;

    logic       hazard;
    logic [1:0] fa_next, fb_next;

    // The EX/MEM producer is checked first because it holds the newest value of the register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       uses,
        input logic [4:0] exd,
        input logic       exw,
        input logic [4:0] memd,
        input logic       memw
    );
        if (uses && exw && (exd != 5'd0) && (exd == src))
            return SEL_EXMEM;
        else if (uses && memw && (memd != 5'd0) && (memd == src))
            return SEL_MEMWB;
        else
            return SEL_IDEX;
    endfunction

    assign hazard = ex_memread & ex_regwrite & (ex_dest != 5'd0) & id_valid &
                    ((id_uses_rs & (ex_dest == id_rs)) | (id_uses_rt & (ex_dest == id_rt)));

    // A squashed instruction is discarded anyway, so it must never hold the front end.
    assign stall       = hazard & ~flush;
    assign idex_bubble = stall | flush | ~id_valid;

    assign fa_next = fwd_sel(id_rs, id_uses_rs, ex_dest, ex_regwrite, mem_dest, mem_regwrite);
    assign fb_next = fwd_sel(id_rt, id_uses_rt, ex_dest, ex_regwrite, mem_dest, mem_regwrite);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_dest      <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_dest     <= '0;
            mem_regwrite <= 1'b0;
            wb_dest      <= '0;
            wb_regwrite  <= 1'b0;
            fa           <= SEL_IDEX;
            fb           <= SEL_IDEX;
            stall_count  <= '0;
        end else begin
            wb_dest      <= mem_dest;
            wb_regwrite  <= mem_regwrite;
            mem_dest     <= ex_dest;
            mem_regwrite <= ex_regwrite;

            if (idex_bubble) begin
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_dest     <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                fa          <= SEL_IDEX;
                fb          <= SEL_IDEX;
            end else begin
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_dest     <= id_dest;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                fa          <= fa_next;
                fb          <= fb_next;
            end

            if (stall && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the five-stage pipelined MIPS core. It tracks register sources and destinations of in-flight instructions through its own ID/EX, EX/MEM and MEM/WB shadow registers. It produces the 2-bit forwarding selects consumed by the EX-stage forwarding mux (00 = ID/EX register, 01 = MEM/WB destination, 10 = EX/MEM destination). It also produces the stall and bubble controls for PC, IF/ID and ID/EX.

## Interface

Parameters:
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  rs field of ID instruction
- id_rt  in  5  rt field of ID instruction
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_dest  in  5  destination register selected in ID (rd or rt)
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- flush  in  1  discard ID instruction (taken branch/jump)
- fa  out  2  forward select for operand A, valid during EX
- fb  out  2  forward select for operand B, valid during EX
- stall  out  1  load-use hazard; hold PC and IF/ID
- idex_bubble  out  1  ID/EX loads a bubble this edge
- stall_count  out  CNT_W  number of stall cycles since reset, saturating

## Operation

- State: ex_{rs,rt,dest,regwrite,memread}, mem_{dest,regwrite}, wb_{dest,regwrite}, fa, fb, stall_count.
- hazard = ex_memread & ex_regwrite & (ex_dest != 0) & id_valid & ((id_uses_rs & ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)).
- stall = hazard & ~flush. Flush has priority; a squashed instruction never stalls.
- idex_bubble = stall | flush | ~id_valid.
- Every edge, not reset:
  - wb <= mem.
  - mem <= {ex_dest, ex_regwrite}.
  - If idex_bubble, ex fields <= 0 and fa, fb <= 00.
  - Otherwise, ex fields <= ID inputs, and fa and fb are computed from the pre-edge state.
- fa computation for a real instruction:
  - 10 if ex_regwrite & ex_dest != 0 & ex_dest == id_rs & id_uses_rs.
  - Else 01 if mem_regwrite & mem_dest != 0 & mem_dest == id_rs & id_uses_rs.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
- fb: identical, using id_rt and id_uses_rt.
- Register $0 is never forwarded.
- The register file is write-before-read. An instruction in WB while the consumer is in ID needs no forwarding. wb state is kept for debug and visibility only.
- stall_count increments on each edge where stall = 1 and saturates at 2^CNT_W − 1.

## Timing

- Reset (synchronous): all state registers 0. Next cycle: fa = fb = 00, stall = 0, stall_count = 0. idex_bubble then equals ~id_valid | flush.
- fa and fb are registered. They are valid for the whole cycle the instruction occupies EX, one cycle after it was in ID.
- stall and idex_bubble are combinational from registered state plus current ID inputs, and are valid in the same cycle.
- Load-use costs exactly one stall cycle:
  - Cycle N: stall = 1 and a bubble is inserted.
  - Cycle N+1: the load is in MEM, stall = 0, and the consumer enters EX at N+2 with select 01.
- Back-to-back loads each feeding the next instruction: one stall per pair, with no merging.
- reset asserted mid-stall: next cycle stall = 0, all selects 00, in-flight tracking is discarded.
- flush and hazard in the same cycle: stall = 0, idex_bubble = 1, and stall_count is unchanged.

## Test plan

- Reset: hold reset 2 cycles with id_valid = 1. Required: fa = fb = 00, stall = 0, stall_count = 0 after release.
- EX/MEM forward: add $3,$1,$2 then sub $4,$3,$5 on consecutive cycles. Required: fa = 10, fb = 00 while sub is in EX.
- MEM/WB forward and priority:
  - add $3…, nop, or $6,$3,$3: required fa = fb = 01 for or.
  - add $3…; add $3…; and $7,$3,$0: required fa = 10 (newest wins), fb = 00 ($0 is never forwarded).
- Load-use: lw $8,0($1) then add $9,$8,$2. Required: stall = 1 and idex_bubble = 1 for exactly one cycle, add enters EX with fa = 01, stall_count = 1.
- Flush vs hazard: lw $8, then add $9,$8,$8 with flush = 1 in the hazard cycle. Required: stall = 0, idex_bubble = 1, stall_count unchanged, next EX selects 00.
- Saturation: with CNT_W = 4, force 20 load-use stalls. Required: stall_count = 15 and it holds there.
